// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: BCD minutes:seconds countdown with prescaler, coin-add, hold and expiry flag.
// Define LOW_TIME_WARN_EN to drive Warning for the last 0:01..0:09 seconds.
module countdown_timer_bcd #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                    Clk,
  input  logic                    nReset,
  input  logic [4*MIN_DIGITS-1:0] Preset,
  input  logic                    Load,
  input  logic                    Add,
  input  logic                    Enable,
  input  logic                    Clear,
  output logic [4*MIN_DIGITS+7:0] PresentTime,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Expired,
  output logic                    Warning
);
  localparam int MW = 4*MIN_DIGITS;
  localparam int TW = MW+8;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV-1);
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, RUN = 2'd2, DONE = 2'd3;

  logic [1:0] st, ns;
  logic [PW-1:0] pre, np;
  logic [TW-1:0] nt, base, dec;
  logic [MW-1:0] pm;
  logic run, tick, nexp;

  function automatic logic [MW-1:0] clamp(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    r = m;
    for (int i = 0; i < MIN_DIGITS; i++) r[4*i +: 4] = r[4*i +: 4] > 4'd9 ? 4'd9 : r[4*i +: 4];
    return r;
  endfunction

  // Saturating +1:00; a full minute field jumps straight to all-9s:59
  function automatic logic [TW-1:0] add_min(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    logic c, n9;
    r = t;
    c = 1'b1;
    n9 = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) n9 = n9 & (t[8+4*i +: 4] == 4'd9);
    for (int i = 0; i < MIN_DIGITS; i++)
      if (c) begin
        c = r[8+4*i +: 4] == 4'd9;
        r[8+4*i +: 4] = c ? 4'd0 : r[8+4*i +: 4] + 4'd1;
      end
    return n9 ? {{MIN_DIGITS{4'd9}}, 8'h59} : r;
  endfunction

  function automatic logic [TW-1:0] dec1(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    logic b;
    r = t;
    b = r[3:0] == 4'd0;
    r[3:0] = b ? 4'd9 : r[3:0] - 4'd1;
    if (b) begin
      b = r[7:4] == 4'd0;
      r[7:4] = b ? 4'd5 : r[7:4] - 4'd1;
    end
    for (int i = 0; i < MIN_DIGITS; i++)
      if (b) begin
        b = r[8+4*i +: 4] == 4'd0;
        r[8+4*i +: 4] = b ? 4'd9 : r[8+4*i +: 4] - 4'd1;
      end
    return r;
  endfunction

  always_comb begin
    pm = clamp(Preset);
    run = st == RUN && Enable;
    tick = run && pre == PMAX;
    base = Add ? add_min(PresentTime) : PresentTime;
    dec = dec1(base);
    ns = st;
    nt = PresentTime;
    np = run ? (tick ? '0 : pre + 1'b1) : pre;
    nexp = 1'b0;
    if (Clear) begin
      ns = IDLE;
      nt = '0;
      np = '0;
    end else if (Load) begin
      ns = pm == '0 ? IDLE : run ? RUN : HOLD;
      nt = {pm, 8'h00};
      np = '0;
    end else begin
      nt = tick ? dec : base;
      nexp = tick && dec == '0;
      ns = run ? (nexp ? DONE : RUN) : (Add || st == RUN) ? HOLD : (st == HOLD && Enable) ? RUN : st;
    end
  end

  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      st <= IDLE;
      pre <= '0;
      PresentTime <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
      Expired <= 1'b0;
    end else begin
      st <= ns;
      pre <= np;
      PresentTime <= nt;
      Busy <= ns == RUN;
      Done <= ns == DONE;
      Expired <= nexp;
    end

`ifdef LOW_TIME_WARN_EN
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) Warning <= 1'b0;
    else Warning <= (ns == HOLD || ns == RUN) && nt[TW-1:4] == '0 && nt[3:0] != 4'd0;
`else
  assign Warning = 1'b0;
`endif
endmodule

// File: doc/countdown_timer_bcd.md
# countdown_timer_bcd

Parametrised BCD countdown timer for the coin-operated timing path: presets a minutes:seconds value, counts it down once per second tick while enabled, and flags expiry. Generalises the fixed 1:59/9:59 three-digit counter to a configurable number of minute digits. Adds a clock prescaler, coin-add with saturation, pause/hold, and an explicit state machine with a done/expired indication. Sits between the coin/mode front end and the display driver.

## Interface
- MIN_DIGITS, 2, number of BCD minute digits (1..4); maximum time is all-9s minutes:59
- TICK_DIV, 1, Clk cycles per one-second tick (≥1)
- Clk  input  1  single clock, rising edge
- nReset  input  1  asynchronous, active-low reset
- Preset  input  4*MIN_DIGITS  BCD minutes loaded by Load; digits >9 clamp to 9
- Load  input  1  pulse: time ← Preset:00
- Add  input  1  pulse: add 1:00 (coin)
- Enable  input  1  level: count down while high
- Clear  input  1  pulse: synchronous return to IDLE, time 0
- PresentTime  output  4*MIN_DIGITS+8  BCD {minute digits MSB-first, seconds tens, seconds ones}
- Busy  output  1  high in RUN
- Done  output  1  high in DONE
- Expired  output  1  one-cycle pulse on reaching 0:00 by countdown
- Warning  output  1  low-time warning (see Configuration)

## Operation
- States: IDLE, HOLD, RUN, DONE. Reset: state IDLE, time 0, prescaler 0, all outputs 0.
- Input priority per cycle: Clear > Load > Add > tick.
- IDLE/DONE: Load with nonzero Preset → HOLD, time Preset:00; Load with zero Preset → IDLE, time 0. Add → HOLD, time 1:00.
- HOLD: Enable=1 → RUN. Load/Add apply, stay HOLD.
- RUN: prescaler counts 0..TICK_DIV-1; tick when it equals TICK_DIV-1 (wraps to 0). Tick decrements by 1 s with BCD borrow: seconds ones 0→9 borrows tens; seconds tens 0→5 borrows minutes; minute digits borrow upward. Enable=0 → HOLD, prescaler frozen (not cleared).
- Tick producing 0:00 → DONE, Expired pulse, Done=1.
- Add saturates at max (all 9s:59). Add with tick same cycle: time ← min(time+1:00, max) − 1 s; cannot expire.
- Load in RUN: reload, prescaler ← 0, stay RUN (→ IDLE if Preset zero).
- Clear in any state: IDLE, time 0, prescaler 0, Expired not asserted.
- Reset mid-operation: immediate return to reset values regardless of state.

## Timing
- All outputs registered; Load/Add/Clear effects visible on PresentTime the cycle after sampling.
- HOLD→RUN one cycle after Enable sampled high; first tick TICK_DIV RUN cycles after entry from a cleared prescaler.
- TICK_DIV=1: decrement every RUN cycle.
- Expired high exactly one cycle, same cycle PresentTime first reads 0 and Done rises.
- Done stays high until Load, Add, Clear or reset.

## Configuration
- LOW_TIME_WARN_EN defined: Warning high in RUN or HOLD when all minute digits and seconds tens are 0 and time ≠ 0 (i.e. 0:01..0:09); registered with PresentTime.
- Undefined: Warning port present, tied to 0; no warning logic.

## Test plan
- MIN_DIGITS=2, TICK_DIV=1: Load Preset=01, Enable=1 → 01:00, 00:59 next RUN cycle, 00:00 after 60 ticks with one-cycle Expired, Done=1, Busy=0.
- Load 10, tick → 09:59; Load 00 → stays IDLE, time 00:00, no Expired.
- Time 99:30, Add → 99:59 (saturate); time 00:01 with Add and tick same cycle → 01:00, no Expired, stays RUN.
- TICK_DIV=4, at 00:30 drop Enable for 5 cycles mid-prescale → value frozen, HOLD; re-enable → decrement after remaining prescale cycles only.
- Assert nReset low mid-RUN at 05:17 → PresentTime 0, Busy/Done/Expired/Warning 0 immediately, IDLE.
- With LOW_TIME_WARN_EN: 00:10 Warning=0, 00:09 Warning=1, 00:00 Warning=0; without macro Warning always 0.
